soc_evt_tx: RTL and testbench
=============================

SOC_EVT_TX -- requirements
Module: soc_evt_tx

Interface
REQ-001 Parameter N_SRC, default 4: number of event sources arbitrated.
REQ-002 Parameter EVNT_WIDTH, default 8: event payload width.
REQ-003 Parameter DEPTH, default 8: event buffer slots; power of two, >=2; AW = log2(DEPTH).
REQ-004 Ports (name, direction, width, meaning):
- clk_i in 1: single clock.
- rst_ni in 1: asynchronous active-low reset.
- src_valid_i in N_SRC: per-source event request; held until acked.
- src_data_i in N_SRC*EVNT_WIDTH: per-source event ID; source k occupies bits [k*EVNT_WIDTH +: EVNT_WIDTH].
- src_ack_o out N_SRC: one-hot accept; transfer occurs when src_valid_i[k] & src_ack_o[k].
- evt_wptr_o out AW+1: Gray-coded write pointer to the cluster-side consumer.
- evt_rptr_i in AW+1: Gray-coded read pointer from the consumer (asynchronous domain).
- evt_data_o out DEPTH*EVNT_WIDTH: buffer contents; slot s occupies bits [s*EVNT_WIDTH +: EVNT_WIDTH].
- full_o out 1: buffer full.
- level_o out AW+1: occupied slots as seen locally.

Function
REQ-005 Arbitration: round-robin; grant the first asserted src_valid_i at index >= rr_q, wrapping modulo N_SRC.
REQ-006 src_ack_o is combinational, asserted only for the granted source, and only when full_o=0; otherwise all zero.
REQ-007 On a transfer, rr_q <= (grant+1) mod N_SRC; rr_q is unchanged on cycles without a transfer.
REQ-008 On a transfer, slot wbin_q[AW-1:0] <= granted payload and wbin_q <= wbin_q+1, with wrap modulo 2^(AW+1).
REQ-009 evt_wptr_o is registered Gray(wbin_q). The new slot data and the new pointer appear on the same edge, so latency from accept to visibility is 1 cycle.
REQ-010 evt_rptr_i passes through a 2-flop synchronizer per bit. rbin = Gray-to-binary(synchronized value).
REQ-011 full_o = (wbin_q[AW] != rbin[AW]) and (wbin_q[AW-1:0] == rbin[AW-1:0]); this is combinational from registers.
REQ-012 level_o = wbin_q - rbin, computed modulo 2^(AW+1).
REQ-013 At most one transfer per cycle. Slots not being written hold their value.
REQ-014 When full_o=1, requests stay pending, with no ack and no state change. There is no drop and no overwrite.
REQ-015 A consumer pointer advance first affects full_o/level_o after the second clk_i edge following the change.
REQ-016 Simultaneous read-pointer advance and write in the same cycle: the write is decided on the pre-update full_o; no transfer is lost.
REQ-017 A source dropping valid without an ack is legal; its payload is discarded.

Reset
REQ-018 On rst_ni low, asynchronously clear the following to 0: wbin_q, evt_wptr_o, rr_q, both synchronizer stages, and all slots.
REQ-019 During and after reset: src_ack_o=0 while no valid, full_o=0, level_o=0, evt_data_o=0.
REQ-020 Reset asserted mid-operation discards all buffered events; the consumer is reset by the same global reset.

Structure
REQ-021 Package soc_evt_pkg holds:
- default constants for N_SRC, EVNT_WIDTH, DEPTH;
- the Gray-encode and Gray-decode functions.
REQ-022 Sub-module soc_evt_sync: parameterised-width 2-flop synchronizer with async active-low reset. It is instantiated once, for evt_rptr_i.
REQ-023 The arbiter, pointer logic and slot storage stay flat in soc_evt_tx.

Verification
All scenarios use N_SRC=4, EVNT_WIDTH=8, DEPTH=8.
REQ-024 Single event: src 2 valid with 0x5A after reset -> src_ack_o=0100 in the same cycle; next cycle slot0=0x5A, evt_wptr_o=0001, level_o=1.
REQ-025 Round-robin: all 4 sources valid with 0x10..0x13, rptr tracks wptr -> acks 0001,0010,0100,1000 on consecutive cycles; slots0..3=0x10..0x13.
REQ-026 Full and release:
- evt_rptr_i held 0, src 0 valid for 9 cycles -> 8 acks, then evt_wptr_o=1100, full_o=1, no 9th ack.
- Then set evt_rptr_i=0001 -> full_o drops after 2 edges and the 9th event is written to slot0.
REQ-027 Wrap-around: run 20 events with a consumer trailing by 3 -> evt_wptr_o sequence passes Gray 1000 -> 0000; level_o never exceeds 3+1; no ack while full.
REQ-028 Reset mid-operation: 5 events buffered, pulse rst_ni low asynchronously mid-cycle -> all outputs 0 immediately; the next event lands in slot0.
REQ-029 Simultaneous: buffer full while rptr advances and src 1 is valid -> no ack until 2 edges later; exactly one write afterwards; no data corruption on any slot.

Source files
------------

// File: rtl/soc_evt_pkg.sv
// Shared constants and Gray-code helpers for the event transmitter.
package soc_evt_pkg;

   localparam int N_SRC_DEF      = 4;
   localparam int EVNT_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 8;

   // Widest pointer the helpers handle; narrower pointers are zero-extended.
   localparam int GRAY_W = 16;

   // Binary to reflected Gray code.
   function automatic logic [GRAY_W-1:0] gray_enc(input logic [GRAY_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Reflected Gray code back to binary (prefix XOR from the MSB down).
   function automatic logic [GRAY_W-1:0] gray_dec(input logic [GRAY_W-1:0] gray);
      logic [GRAY_W-1:0] bin;
      bin[GRAY_W-1] = gray[GRAY_W-1];
      for (int i = GRAY_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/soc_evt_sync.sv
// Two-flop synchronizer for a Gray-coded bus from another clock domain.
module soc_evt_sync
   import soc_evt_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Capture the foreign bus, then re-register to settle metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/soc_evt_tx.sv
// Event transmitter: round-robin arbitration of N_SRC event sources into a
// DEPTH-slot buffer exposed to an asynchronous consumer via Gray pointers.
module soc_evt_tx
   import soc_evt_pkg::*;
#(
   parameter  int N_SRC      = N_SRC_DEF,
   parameter  int EVNT_WIDTH = EVNT_WIDTH_DEF,
   parameter  int DEPTH      = DEPTH_DEF,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [N_SRC-1:0]            src_valid_i,
   input  logic [N_SRC*EVNT_WIDTH-1:0] src_data_i,
   output logic [N_SRC-1:0]            src_ack_o,
   output logic [AW:0]                 evt_wptr_o,
   input  logic [AW:0]                 evt_rptr_i,
   output logic [DEPTH*EVNT_WIDTH-1:0] evt_data_o,
   output logic                        full_o,
   output logic [AW:0]                 level_o
);

   localparam int PW  = AW + 1;
   localparam int RRW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [PW-1:0]         wbin_q;
   logic [PW-1:0]         wbin_inc;
   logic [RRW-1:0]        rr_q;
   logic [EVNT_WIDTH-1:0] slot_q [DEPTH];

   logic [PW-1:0]         rptr_sync;
   logic [PW-1:0]         rbin;
   logic                  found;
   logic [RRW-1:0]        grant;
   logic [RRW-1:0]        scan_idx;
   logic                  transfer;
   logic [EVNT_WIDTH-1:0] grant_data;

   soc_evt_sync #(
      .WIDTH (PW)
   ) u_rptr_sync (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .d     (evt_rptr_i),
      .q     (rptr_sync)
   );

   // Bring the synchronized consumer pointer back to binary.
   always_comb begin
      rbin = PW'(gray_dec(GRAY_W'(rptr_sync)));
   end

   // Occupancy as seen locally; full when the pointers differ only in the wrap bit.
   always_comb begin
      full_o  = (wbin_q[AW] != rbin[AW]) && (wbin_q[AW-1:0] == rbin[AW-1:0]);
      level_o = wbin_q - rbin;
   end

   // Round-robin search: first valid source at or after rr_q, wrapping.
   always_comb begin
      found    = 1'b0;
      grant    = '0;
      scan_idx = '0;
      for (int i = 0; i < N_SRC; i++) begin
         scan_idx = RRW'((int'(rr_q) + i) % N_SRC);
         if (!found && src_valid_i[scan_idx]) begin
            found = 1'b1;
            grant = scan_idx;
         end else begin
            found = found;
         end
      end
   end

   // Accept only when there is room; a full buffer leaves requests pending.
   always_comb begin
      src_ack_o  = '0;
      transfer   = found && !full_o;
      grant_data = src_data_i[int'(grant)*EVNT_WIDTH +: EVNT_WIDTH];
      wbin_inc   = wbin_q + PW'(1);
      if (transfer) begin
         src_ack_o[grant] = 1'b1;
      end else begin
         src_ack_o = '0;
      end
   end

   // Write the granted payload and publish the new Gray pointer on the same edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wbin_q     <= '0;
         evt_wptr_o <= '0;
         rr_q       <= '0;
         for (int s = 0; s < DEPTH; s++) begin
            slot_q[s] <= '0;
         end
      end else if (transfer) begin
         slot_q[wbin_q[AW-1:0]] <= grant_data;
         wbin_q                 <= wbin_inc;
         evt_wptr_o             <= PW'(gray_enc(GRAY_W'(wbin_inc)));
         if (int'(grant) == N_SRC - 1) begin
            rr_q <= '0;
         end else begin
            rr_q <= grant + RRW'(1);
         end
      end
   end

   // Flatten slot storage onto the consumer-visible bus.
   always_comb begin
      evt_data_o = '0;
      for (int s = 0; s < DEPTH; s++) begin
         evt_data_o[s*EVNT_WIDTH +: EVNT_WIDTH] = slot_q[s];
      end
   end

endmodule

// File: tb/tb_soc_evt_tx.sv
// Directed self-checking bench for soc_evt_tx (N_SRC=4, EVNT_WIDTH=8, DEPTH=8).
module tb_soc_evt_tx;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [3:0]  src_valid = 4'b0000;
   logic [31:0] src_data = 32'h0;
   logic [3:0]  src_ack;
   logic [3:0]  evt_wptr;
   logic [3:0]  evt_rptr = 4'b0000;
   logic [63:0] evt_data;
   logic        full;
   logic [3:0]  level;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   soc_evt_tx #(
      .N_SRC      (4),
      .EVNT_WIDTH (8),
      .DEPTH      (8)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .src_valid_i (src_valid),
      .src_data_i  (src_data),
      .src_ack_o   (src_ack),
      .evt_wptr_o  (evt_wptr),
      .evt_rptr_i  (evt_rptr),
      .evt_data_o  (evt_data),
      .full_o      (full),
      .level_o     (level)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gray4(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic do_reset();
      rst_ni = 1'b0; src_valid = 4'b0000; src_data = 32'h0; evt_rptr = 4'b0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      chk_cnt++; if (src_ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=0000", src_ack); else pass_cnt++;
      chk_cnt++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else pass_cnt++;
      chk_cnt++; if (level !== 4'd0) $display("FAIL reset_level got=%0d exp=0", level); else pass_cnt++;
      chk_cnt++; if (evt_wptr !== 4'b0000) $display("FAIL reset_wptr got=%b exp=0000", evt_wptr); else pass_cnt++;
      chk_cnt++; if (evt_data !== 64'h0) $display("FAIL reset_data got=%h exp=0", evt_data); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      src_data[23:16] = 8'h5A; src_valid = 4'b0100; #1;
      chk_cnt++; if (src_ack !== 4'b0100) $display("FAIL single_ack got=%b exp=0100", src_ack); else pass_cnt++;
      @(posedge clk); #1; src_valid = 4'b0000; #1;
      chk_cnt++; if (evt_data[7:0] !== 8'h5A) $display("FAIL single_slot0 got=%h exp=5a", evt_data[7:0]); else pass_cnt++;
      chk_cnt++; if (evt_wptr !== 4'b0001) $display("FAIL single_wptr got=%b exp=0001", evt_wptr); else pass_cnt++;
      chk_cnt++; if (level !== 4'd1) $display("FAIL single_level got=%0d exp=1", level); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ack [4];
      logic [7:0] exp_b;
      exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100; exp_ack[3] = 4'b1000;
      do_reset();
      for (int k = 0; k < 4; k++) src_data[k*8 +: 8] = 8'(8'h10 + k);
      src_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk_cnt++; if (src_ack !== exp_ack[k]) $display("FAIL rr_ack%0d got=%b exp=%b", k, src_ack, exp_ack[k]); else pass_cnt++;
         @(posedge clk); #1;
         src_valid[k] = 1'b0;
         evt_rptr = evt_wptr;
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_b = 8'(8'h10 + k);
         chk_cnt++; if (evt_data[k*8 +: 8] !== exp_b) $display("FAIL rr_slot%0d got=%h exp=%h", k, evt_data[k*8 +: 8], exp_b); else pass_cnt++;
      end
      chk_cnt++; if (evt_wptr !== 4'b0110) $display("FAIL rr_wptr got=%b exp=0110", evt_wptr); else pass_cnt++;
   endtask

   task automatic test_full_release();
      logic [3:0] exp_ack;
      do_reset();
      src_valid = 4'b0001;
      for (int n = 0; n < 9; n++) begin
         src_data[7:0] = 8'(8'hA0 + n);
         exp_ack = (n < 8) ? 4'b0001 : 4'b0000;
         #1;
         chk_cnt++; if (src_ack !== exp_ack) $display("FAIL full_ack%0d got=%b exp=%b", n, src_ack, exp_ack); else pass_cnt++;
         @(posedge clk); #1;
      end
      chk_cnt++; if (evt_wptr !== 4'b1100) $display("FAIL full_wptr got=%b exp=1100", evt_wptr); else pass_cnt++;
      chk_cnt++; if (full !== 1'b1) $display("FAIL full_flag got=%b exp=1", full); else pass_cnt++;
      chk_cnt++; if (level !== 4'd8) $display("FAIL full_level got=%0d exp=8", level); else pass_cnt++;
      evt_rptr = 4'b0001;
      @(posedge clk); #1;
      chk_cnt++; if (full !== 1'b1) $display("FAIL release_e1_full got=%b exp=1", full); else pass_cnt++;
      chk_cnt++; if (src_ack !== 4'b0000) $display("FAIL release_e1_ack got=%b exp=0000", src_ack); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (full !== 1'b0) $display("FAIL release_e2_full got=%b exp=0", full); else pass_cnt++;
      chk_cnt++; if (src_ack !== 4'b0001) $display("FAIL release_e2_ack got=%b exp=0001", src_ack); else pass_cnt++;
      chk_cnt++; if (level !== 4'd7) $display("FAIL release_e2_level got=%0d exp=7", level); else pass_cnt++;
      @(posedge clk); #1; src_valid = 4'b0000; #1;
      chk_cnt++; if (evt_data[7:0] !== 8'hA8) $display("FAIL release_slot0 got=%h exp=a8", evt_data[7:0]); else pass_cnt++;
      chk_cnt++; if (evt_data[15:8] !== 8'hA1) $display("FAIL release_slot1 got=%h exp=a1", evt_data[15:8]); else pass_cnt++;
      chk_cnt++; if (evt_wptr !== 4'b1101) $display("FAIL release_wptr got=%b exp=1101", evt_wptr); else pass_cnt++;
      chk_cnt++; if (full !== 1'b1) $display("FAIL release_refull got=%b exp=1", full); else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp_b;
      do_reset();
      src_valid = 4'b0001;
      for (int n = 0; n < 8; n++) begin
         src_data[7:0] = 8'(8'h30 + n);
         @(posedge clk); #1;
      end
      src_valid = 4'b0010; src_data[15:8] = 8'h77; evt_rptr = 4'b0001; #1;
      chk_cnt++; if (src_ack !== 4'b0000) $display("FAIL sim_e0_ack got=%b exp=0000", src_ack); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (src_ack !== 4'b0000) $display("FAIL sim_e1_ack got=%b exp=0000", src_ack); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (src_ack !== 4'b0010) $display("FAIL sim_e2_ack got=%b exp=0010", src_ack); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (src_ack !== 4'b0000) $display("FAIL sim_e3_ack got=%b exp=0000", src_ack); else pass_cnt++;
      @(posedge clk); #1; src_valid = 4'b0000; #1;
      chk_cnt++; if (evt_wptr !== 4'b1101) $display("FAIL sim_wptr got=%b exp=1101", evt_wptr); else pass_cnt++;
      chk_cnt++; if (level !== 4'd8) $display("FAIL sim_level got=%0d exp=8", level); else pass_cnt++;
      chk_cnt++; if (evt_data[7:0] !== 8'h77) $display("FAIL sim_slot0 got=%h exp=77", evt_data[7:0]); else pass_cnt++;
      for (int s = 1; s < 8; s++) begin
         exp_b = 8'(8'h30 + s);
         chk_cnt++; if (evt_data[s*8 +: 8] !== exp_b) $display("FAIL sim_slot%0d got=%h exp=%h", s, evt_data[s*8 +: 8], exp_b); else pass_cnt++;
      end
   endtask

   task automatic test_wrap();
      int         wcount;
      logic       acked;
      logic       seen_wrap;
      logic [3:0] prev_wptr;
      do_reset();
      wcount = 0; seen_wrap = 1'b0; prev_wptr = 4'b0000;
      for (int cyc = 0; cyc < 46; cyc++) begin
         if ((cyc % 2 == 0) && (wcount < 20)) begin
            src_valid = 4'b0001; src_data[7:0] = 8'(8'h40 + wcount);
         end else begin
            src_valid = 4'b0000;
         end
         #1;
         chk_cnt++; if (full && (src_ack !== 4'b0000)) $display("FAIL wrap_ack_while_full cyc=%0d got=%b exp=0000", cyc, src_ack); else pass_cnt++;
         chk_cnt++; if (level > 4'd4) $display("FAIL wrap_level cyc=%0d got=%0d exp<=4", cyc, level); else pass_cnt++;
         acked = src_ack[0];
         @(posedge clk); #1;
         if (acked) wcount++;
         if ((prev_wptr == 4'b1000) && (evt_wptr != prev_wptr)) begin
            seen_wrap = 1'b1;
            chk_cnt++; if (evt_wptr !== 4'b0000) $display("FAIL wrap_gray got=%b exp=0000", evt_wptr); else pass_cnt++;
         end
         prev_wptr = evt_wptr;
         evt_rptr = gray4(4'((wcount >= 3) ? (wcount - 3) : 0));
      end
      chk_cnt++; if (wcount !== 20) $display("FAIL wrap_count got=%0d exp=20", wcount); else pass_cnt++;
      chk_cnt++; if (seen_wrap !== 1'b1) $display("FAIL wrap_seen got=%b exp=1", seen_wrap); else pass_cnt++;
      chk_cnt++; if (evt_wptr !== 4'b0110) $display("FAIL wrap_wptr got=%b exp=0110", evt_wptr); else pass_cnt++;
      chk_cnt++; if (evt_data[31:24] !== 8'h53) $display("FAIL wrap_slot3 got=%h exp=53", evt_data[31:24]); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      src_valid = 4'b0001;
      for (int n = 0; n < 5; n++) begin
         src_data[7:0] = 8'(8'h60 + n);
         @(posedge clk); #1;
      end
      src_valid = 4'b0000; #1;
      chk_cnt++; if (level !== 4'd5) $display("FAIL mid_level got=%0d exp=5", level); else pass_cnt++;
      chk_cnt++; if (evt_wptr !== 4'b0111) $display("FAIL mid_wptr got=%b exp=0111", evt_wptr); else pass_cnt++;
      @(posedge clk); #3;
      rst_ni = 1'b0; #1;
      chk_cnt++; if (evt_wptr !== 4'b0000) $display("FAIL mid_rst_wptr got=%b exp=0000", evt_wptr); else pass_cnt++;
      chk_cnt++; if (level !== 4'd0) $display("FAIL mid_rst_level got=%0d exp=0", level); else pass_cnt++;
      chk_cnt++; if (full !== 1'b0) $display("FAIL mid_rst_full got=%b exp=0", full); else pass_cnt++;
      chk_cnt++; if (evt_data !== 64'h0) $display("FAIL mid_rst_data got=%h exp=0", evt_data); else pass_cnt++;
      chk_cnt++; if (src_ack !== 4'b0000) $display("FAIL mid_rst_ack got=%b exp=0000", src_ack); else pass_cnt++;
      #2; rst_ni = 1'b1;
      @(posedge clk); #1;
      src_valid = 4'b1000; src_data[31:24] = 8'hC3; #1;
      chk_cnt++; if (src_ack !== 4'b1000) $display("FAIL mid_post_ack got=%b exp=1000", src_ack); else pass_cnt++;
      @(posedge clk); #1; src_valid = 4'b0000; #1;
      chk_cnt++; if (evt_data[7:0] !== 8'hC3) $display("FAIL mid_post_slot0 got=%h exp=c3", evt_data[7:0]); else pass_cnt++;
      chk_cnt++; if (evt_wptr !== 4'b0001) $display("FAIL mid_post_wptr got=%b exp=0001", evt_wptr); else pass_cnt++;
      chk_cnt++; if (level !== 4'd1) $display("FAIL mid_post_level got=%0d exp=1", level); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_release();
      test_simultaneous();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
